// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - state encoding and widths shared by the PLL lock sequencer
package pll_seq_pkg;

    localparam int CNT_W   = 16;
    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchronizer for the asynchronous PLL lock indicator
module pll_lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock/stability sequencer with bounded retries
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state_dbg
);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    pll_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lock_lost_q, lock_lost_d;
    logic               locked_s;

    pll_lock_sync u_sync (
        .clk_i   (refclk),
        .rst_i   (rst),
        .async_i (pll_locked),
        .sync_o  (locked_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    // Every state change clears cnt, so terminal compares never see a wrapped count.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        if (relock_req) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_RESET_PLL;
                            retry_d = retry_q + RETRY_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                    if (!locked_s) begin
                        state_d     = ST_RESET_PLL;
                        retry_d     = '0;
                        lock_lost_d = 1'b1;
                    end
                end
                ST_FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign pll_rst   = (state_q == ST_RESET_PLL) || (state_q == ST_FAIL);
    assign ready     = (state_q == ST_RUN);
    assign fail      = (state_q == ST_FAIL);
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed and random checks of pll_lock_sequencer against a timeline model
module tb_pll_lock_sequencer;

    localparam int RST_C = 4;
    localparam int TO_C  = 20;
    localparam int ST_C  = 8;
    localparam int MR_C  = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, ready, lock_lost, fail;
    logic [3:0] retry_cnt;
    logic [2:0] state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: mode number, cycles spent in the mode, retries, sampled-lock history.
    int       m_mode = 0;
    int       m_elapsed = 0;
    int       m_retry = 0;
    bit       m_lost = 1'b0;
    bit [1:0] m_hist = 2'b00;
    bit       m_valid = 1'b0;

    always #5 refclk = ~refclk;

    pll_lock_sequencer #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TO_C),
        .STABLE_CYCLES (ST_C),
        .MAX_RETRY     (MR_C)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .state_dbg  (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic enter(input int mode);
        m_mode    = mode;
        m_elapsed = 0;
    endtask

    task automatic model_edge(input bit r, input bit l, input bit q);
        bit seen;
        seen   = m_hist[1];
        m_hist = {m_hist[0], l};
        m_lost = 1'b0;
        if (r) begin
            m_hist  = 2'b00;
            m_retry = 0;
            m_valid = 1'b1;
            enter(0);
        end else if (q) begin
            m_retry = 0;
            enter(0);
        end else begin
            m_elapsed++;
            case (m_mode)
                0: if (m_elapsed == RST_C) enter(1);
                1: begin
                    if (seen) enter(2);
                    else if (m_elapsed == TO_C) begin
                        if (m_retry == MR_C) enter(4);
                        else begin
                            m_retry++;
                            enter(0);
                        end
                    end
                end
                2: begin
                    if (!seen) enter(1);
                    else if (m_elapsed == ST_C) enter(3);
                end
                3: begin
                    if (!seen) begin
                        m_lost  = 1'b1;
                        m_retry = 0;
                        enter(0);
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] exp_vec();
        logic [2:0] md;
        logic [3:0] rt;
        md = 3'(m_mode);
        rt = 4'(m_retry);
        return {21'd0, md, (m_mode == 0 || m_mode == 4), (m_mode == 3), (m_mode == 4), m_lost, rt};
    endfunction

    task automatic step(input bit r, input bit l, input bit q);
        rst        = r;
        pll_locked = l;
        relock_req = q;
        @(posedge refclk);
        model_edge(r, l, q);
        @(negedge refclk);
        if (m_valid)
            chk("cycle", {21'd0, state_dbg, pll_rst, ready, fail, lock_lost, retry_cnt}, exp_vec());
    endtask

    task automatic count_hi(input bit l, output int hi);
        hi = 0;
        while (hi < 40 && pll_rst) begin
            hi++;
            step(1'b0, l, 1'b0);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (n < 60 && !ready) begin
            step(1'b0, 1'b1, 1'b0);
            n++;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {25'd0, state_dbg, pll_rst, ready, fail, retry_cnt == 4'd0, lock_lost},
            {25'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    endtask

    initial begin
        int hi, n, per, exp_retry;
        bit exp_rst, exp_fail, lk;

        // Reset state
        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk_idle("reset_state");

        // Normal lock
        count_hi(1'b0, hi);
        chk("normal_rst_len", hi, RST_C);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        wait_ready(n);
        chk("normal_ready_latency", n, 3 + ST_C);
        chk("normal_retry", retry_cnt, 0);

        // Loss in RUN: drop captured at the first edge, pulse two edges later
        step(1'b0, 1'b0, 1'b0);
        chk("loss_no_early_pulse", lock_lost, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("loss_still_ready", ready, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("loss_pulse", lock_lost, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("loss_pulse_once", lock_lost, 0);
        chk("loss_after", {pll_rst, ready}, 2'b10);

        // Loss coinciding with relock_req
        wait_ready(n);
        chk("relock_reach_run", ready, 1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("prio_no_pulse", lock_lost, 0);
        chk("prio_state", state_dbg, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("prio_no_pulse_late", lock_lost, 0);

        // Timeout and FAIL timeline
        step(1'b1, 1'b0, 1'b0);
        per = RST_C + TO_C;
        for (int k = 0; k < per * (MR_C + 1) + 4; k++) begin
            exp_fail  = (k >= per * (MR_C + 1));
            exp_rst   = exp_fail || ((k % per) < RST_C);
            exp_retry = exp_fail ? MR_C : k / per;
            chk("timeout_timeline", {pll_rst, fail, retry_cnt}, {exp_rst, exp_fail, 4'(exp_retry)});
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1);
        chk_idle("fail_relock");
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        count_hi(1'b0, hi);
        chk("relock_restart_len", hi, RST_C);

        // Stability abort with one failed attempt already recorded
        for (int i = 0; i < 100 && !(retry_cnt == 4'd1 && state_dbg == 3'd1); i++)
            step(1'b0, 1'b0, 1'b0);
        chk("abort_setup", {retry_cnt, state_dbg}, {4'd1, 3'd1});
        repeat (5) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("abort_back_to_wait", state_dbg, 1);
        wait_ready(n);
        chk("abort_ready_latency", n + 2, 3 + ST_C);
        chk("abort_retry_kept", retry_cnt, 1);

        // Reset in RUN, STABLE and FAIL
        step(1'b1, 1'b1, 1'b0);
        chk_idle("rst_in_run");
        for (int i = 0; i < 40 && state_dbg != 3'd2; i++) step(1'b0, 1'b1, 1'b0);
        chk("reach_stable", state_dbg, 2);
        step(1'b1, 1'b1, 1'b0);
        chk_idle("rst_in_stable");
        for (int i = 0; i < 200 && !fail; i++) step(1'b0, 1'b0, 1'b0);
        chk("reach_fail", fail, 1);
        step(1'b1, 1'b0, 1'b0);
        chk_idle("rst_in_fail");

        // Random traffic against the model
        lk = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(lk ? 31 : 11) == 0) lk = !lk;
            step($urandom_range(499) == 0, lk, $urandom_range(199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16: cycles the PLL reset is held per attempt (range 1..65535).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 65535: WAIT_LOCK cycles before an attempt fails (range 1..65535).
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 1024: consecutive locked cycles required before ready (range 1..65535).
REQ-004 The block SHALL have parameter MAX_RETRY, default 3: retries after the first attempt before FAIL (range 0..15).
REQ-005 The block SHALL have port refclk, input, 1 bit: the single clock (PLL reference clock).
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port pll_locked, input, 1 bit: PLL lock indicator, asynchronous to refclk.
REQ-008 The block SHALL have port relock_req, input, 1 bit: one-cycle request to restart the sequence.
REQ-009 The block SHALL have port pll_rst, output, 1 bit: drives the PLL rst input.
REQ-010 The block SHALL have port ready, output, 1 bit: the PLL output clock is valid and stable.
REQ-011 The block SHALL have port lock_lost, output, 1 bit: one-cycle pulse on unrequested loss of lock while in RUN.
REQ-012 The block SHALL have port fail, output, 1 bit: all attempts have been exhausted.
REQ-013 The block SHALL have port retry_cnt, output, 4 bits: failed attempts in the current sequence.
REQ-014 The block SHALL have port state_dbg, output, 3 bits: the current state encoding.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; locked_s lags pll_locked by 2 cycles.
REQ-016 The FSM SHALL have states RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4, with a single 16-bit cycle counter cnt.
REQ-017 Outputs SHALL be decoded from the state register: pll_rst=1 in RESET_PLL and FAIL; ready=1 only in RUN; fail=1 only in FAIL.
REQ-018 In RESET_PLL, cnt SHALL count 0..RST_CYCLES-1; at cnt==RST_CYCLES-1 the FSM SHALL go to WAIT_LOCK with cnt=0, so pll_rst is high for exactly RST_CYCLES cycles.
REQ-019 In WAIT_LOCK with locked_s=1, the FSM SHALL go to STABLE with cnt=0.
REQ-020 In WAIT_LOCK with locked_s=0 and cnt==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRY the FSM SHALL go to FAIL, otherwise it SHALL increment retry_cnt and go to RESET_PLL with cnt=0.
REQ-021 In STABLE, locked_s=0 SHALL return the FSM to WAIT_LOCK with cnt=0 and retry_cnt unchanged.
REQ-022 In STABLE, the cycle in which cnt==STABLE_CYCLES-1 with locked_s=1 SHALL move the FSM to RUN, so ready rises 3+STABLE_CYCLES cycles after pll_locked rises.
REQ-023 In RUN, locked_s=0 SHALL pulse lock_lost for exactly 1 cycle (registered), move the FSM to RESET_PLL, and clear retry_cnt and cnt.
REQ-024 relock_req=1 in any state SHALL go to RESET_PLL and clear cnt, retry_cnt and fail; it is the only exit from FAIL other than rst.
REQ-025 relock_req SHALL take priority over a simultaneous lock loss in RUN: no lock_lost pulse.
REQ-026 A relock_req arriving while already in RESET_PLL SHALL restart the full RST_CYCLES hold.
REQ-027 The counter SHALL never wrap: it is cleared on every state change, and every terminal compare uses the parameter value minus 1.
REQ-028 A pll_locked glitch shorter than 1 cycle MAY be missed; any locked_s=0 sample SHALL be treated as loss of lock.

Reset
REQ-029 rst=1 SHALL have priority over all other inputs at every clock edge.
REQ-030 rst SHALL set: state=RESET_PLL, cnt=0, retry_cnt=0, synchronizer flops=0, lock_lost=0.
REQ-031 Hence during and after rst: pll_rst=1, ready=0, fail=0, state_dbg=0.
REQ-032 rst asserted mid-sequence, including in RUN or FAIL, SHALL abort the sequence with no lock_lost pulse.

Structure
REQ-033 Package pll_seq_pkg SHALL hold the state enum (3-bit), the counter width constant (16) and the retry width constant (4).
REQ-034 The synchronizer SHALL be the sub-module pll_lock_sync (2-flop, synchronous reset to 0), instantiated once.

Verification
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
REQ-035 Normal lock: release rst; raise pll_locked 5 cycles after pll_rst falls -> pll_rst high exactly 4 cycles, ready rises exactly 11 cycles after pll_locked rises, retry_cnt=0.
REQ-036 Timeout/FAIL: hold pll_locked=0 -> pll_rst pulses 3 times (4 cycles each) separated by 20 low cycles, retry_cnt steps 1,2, then fail=1 with pll_rst=1 held; relock_req -> fail=0, retry_cnt=0, new 4-cycle reset.
REQ-037 Stability abort: lock for 5 cycles, drop for 1, relock -> FSM returns to WAIT_LOCK, ready delayed until 8 full consecutive cycles, retry_cnt unchanged.
REQ-038 Loss in RUN: drop pll_locked while ready=1 -> lock_lost high exactly 1 cycle, 2 cycles after the drop, ready=0 and pll_rst=1 on the following cycle; same cycle with relock_req=1 -> no lock_lost pulse.
REQ-039 Reset mid-operation: assert rst in STABLE and again in FAIL -> next cycle state_dbg=0, pll_rst=1, ready=0, fail=0, retry_cnt=0.
